// File: rtl/iddr_deser.sv
// rtl/iddr_deser.sv - DDR input capture (Q1/Q2) with a 1:2N deserializer and word slip
// Define IDDR_WORD_PARITY_EN to add the WORD_PAR output (even parity of WORD).
module iddr_deser #(
  parameter string DDR_CLK_EDGE = "SAME_EDGE_PIPELINED",
  parameter logic  INIT_Q1      = 1'b0,
  parameter logic  INIT_Q2      = 1'b0,
  parameter int    WORD_PAIRS   = 4
) (
  input  logic                    C,
  input  logic                    RN,
  input  logic                    CE,
  input  logic                    D,
  input  logic                    S,
  input  logic                    ALIGN,
  output logic                    Q1,
  output logic                    Q2,
  output logic [2*WORD_PAIRS-1:0] WORD,
`ifdef IDDR_WORD_PARITY_EN
  output logic                    WORD_PAR,
`endif
  output logic                    WORD_VALID
);

  localparam int W  = 2 * WORD_PAIRS;
  localparam int CW = ($clog2(WORD_PAIRS) < 1) ? 1 : $clog2(WORD_PAIRS);
  localparam logic [CW-1:0] LAST = CW'(WORD_PAIRS - 1);
  localparam bit OPP  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
  localparam bit SAME = (DDR_CLK_EDGE == "SAME_EDGE");

  logic          r;
  logic          f;
  logic          q1;
  logic          q2;
  logic          pair_ok;
  logic [W-3:0]  shift;
  logic [CW-1:0] cnt;
  logic [W-1:0]  nxt;

  // Word as it would look if the pair {r, f} were shifted in now.
  assign nxt = {shift, r, f};

  assign Q1 = OPP ? r : q1;
  assign Q2 = OPP ? f : q2;

  always_ff @(negedge C or negedge RN) begin
    if (!RN) begin
      f <= INIT_Q2;
    end else if (S) begin
      f <= 1'b1;
    end else if (CE) begin
      f <= D;
    end
  end

  // pair_ok stays low until a real rise sample exists, so reset values never enter a word.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      r          <= INIT_Q1;
      q1         <= INIT_Q1;
      q2         <= INIT_Q2;
      pair_ok    <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      WORD       <= '0;
      WORD_VALID <= 1'b0;
`ifdef IDDR_WORD_PARITY_EN
      WORD_PAR   <= 1'b0;
`endif
    end else if (S) begin
      r          <= 1'b1;
      q1         <= 1'b1;
      q2         <= 1'b1;
      pair_ok    <= 1'b1;
      cnt        <= '0;
      WORD_VALID <= 1'b0;
    end else if (CE) begin
      r          <= D;
      q1         <= SAME ? D : r;
      q2         <= f;
      pair_ok    <= 1'b1;
      WORD_VALID <= 1'b0;
      if (pair_ok && !ALIGN) begin
        shift <= nxt[W-3:0];
        if (cnt == LAST) begin
          cnt        <= '0;
          WORD       <= nxt;
          WORD_VALID <= 1'b1;
`ifdef IDDR_WORD_PARITY_EN
          WORD_PAR   <= ^nxt;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      WORD_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iddr_deser.sv
// tb/tb_iddr_deser.sv - scoreboard bench for iddr_deser (three alignment modes, WORD_PAIRS=4)
module tb_iddr_deser;

  logic C = 1'b0;
  logic RN = 1'b0;
  logic CE = 1'b0;
  logic D = 1'b0;
  logic S = 1'b0;
  logic ALIGN = 1'b0;

  logic q1_p, q2_p, wv_p, q1_o, q2_o, wv_o, q1_s, q2_s, wv_s;
  logic [7:0] word_p, word_o, word_s;
`ifdef IDDR_WORD_PARITY_EN
  logic par_p, par_o, par_s;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] w;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  int         m_cnt = 0;
  logic [7:0] m_sh = '0;
  logic       pend = 1'b0;
  logic       pr, pf, pa;
  logic       neg_q1_o, neg_q2_o;

  logic [1:0] pat [4] = '{2'b10, 2'b11, 2'b00, 2'b10};
  logic [2:0] slip_seq [14] = '{3'b100, 3'b110, 3'b000, 3'b100, 3'b101,
                                3'b110, 3'b000, 3'b100, 3'b100,
                                3'b110, 3'b000, 3'b100, 3'b101, 3'b100};

  iddr_deser #(.DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .INIT_Q1(1'b1), .INIT_Q2(1'b0), .WORD_PAIRS(4)) dut_p (
    .C(C), .RN(RN), .CE(CE), .D(D), .S(S), .ALIGN(ALIGN), .Q1(q1_p), .Q2(q2_p), .WORD(word_p),
`ifdef IDDR_WORD_PARITY_EN
    .WORD_PAR(par_p),
`endif
    .WORD_VALID(wv_p));

  iddr_deser #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT_Q1(1'b0), .INIT_Q2(1'b0), .WORD_PAIRS(4)) dut_o (
    .C(C), .RN(RN), .CE(CE), .D(D), .S(S), .ALIGN(ALIGN), .Q1(q1_o), .Q2(q2_o), .WORD(word_o),
`ifdef IDDR_WORD_PARITY_EN
    .WORD_PAR(par_o),
`endif
    .WORD_VALID(wv_o));

  iddr_deser #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT_Q1(1'b0), .INIT_Q2(1'b1), .WORD_PAIRS(4)) dut_s (
    .C(C), .RN(RN), .CE(CE), .D(D), .S(S), .ALIGN(ALIGN), .Q1(q1_s), .Q2(q2_s), .WORD(word_s),
`ifdef IDDR_WORD_PARITY_EN
    .WORD_PAR(par_s),
`endif
    .WORD_VALID(wv_s));

  always #5 C = ~C;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d limit=400000ns", cyc);
    $fatal(1, "watchdog");
  end

  // Strobe monitor for the pipelined instance: every cycle is either an expected strobe or silence.
  always @(posedge C) begin
    cyc = cyc + 1;
    #2;
    if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL strobe_missing cyc=%0d got=none exp_cyc=%0d exp_word=%h", cyc, exp_q[0].c, exp_q[0].w);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      checks++;
      if (wv_p !== 1'b1 || word_p !== exp_q[0].w) begin
        errors++;
        $display("FAIL word cyc=%0d got valid=%b word=%h exp valid=1 word=%h", cyc, wv_p, word_p, exp_q[0].w);
      end
`ifdef IDDR_WORD_PARITY_EN
      checks++;
      if (par_p !== ^exp_q[0].w) begin
        errors++;
        $display("FAIL word_par cyc=%0d got=%b exp=%b", cyc, par_p, ^exp_q[0].w);
      end
`endif
      void'(exp_q.pop_front());
    end else begin
      checks++;
      if (wv_p !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d got valid=%b word=%h exp valid=0", cyc, wv_p, word_p);
      end
    end
  end

  task automatic eval_pending();
    if (pend && !pa) begin
      m_sh = {m_sh[5:0], pr, pf};
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back('{w: m_sh, c: cyc});
        m_cnt = 0;
      end
    end
    pend = 1'b0;
  endtask

  task automatic send_pair(input logic b_r, input logic b_f, input logic al);
    @(negedge C);
    #1;
    D = b_r;
    CE = 1'b1;
    S = 1'b0;
    neg_q1_o = q1_o;
    neg_q2_o = q2_o;
    @(posedge C);
    #1;
    eval_pending();
    D = b_f;
    ALIGN = al;
    pend = 1'b1;
    pr = b_r;
    pf = b_f;
    pa = al;
  endtask

  task automatic stall(input int n);
    @(negedge C);
    #1;
    CE = 1'b0;
    repeat (n) @(posedge C);
  endtask

  task automatic finish_stream(input string name);
    @(posedge C);
    #1;
    eval_pending();
    CE = 1'b0;
    ALIGN = 1'b0;
    repeat (3) @(posedge C);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got=%0d pending exp=0", name, exp_q.size());
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge C);
    #2;
    RN = 1'b0;
    CE = 1'b0;
    S = 1'b0;
    ALIGN = 1'b0;
    #1;
    exp_q.delete();
    pend = 1'b0;
    m_cnt = 0;
    m_sh = '0;
    checks++;
    if (q1_p !== 1'b1 || q2_p !== 1'b0 || word_p !== 8'h00 || wv_p !== 1'b0) begin
      errors++;
      $display("FAIL %s_reset got q1=%b q2=%b word=%h valid=%b exp 1 0 00 0", name, q1_p, q2_p, word_p, wv_p);
    end
    checks++;
    if (q1_o !== 1'b0 || q2_o !== 1'b0 || q1_s !== 1'b0 || q2_s !== 1'b1) begin
      errors++;
      $display("FAIL %s_reset_init got opp=%b%b same=%b%b exp opp=00 same=01", name, q1_o, q2_o, q1_s, q2_s);
    end
    @(negedge C);
    #2;
    RN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("initial");
  endtask

  task automatic test_modes();
    do_reset("modes");
    send_pair(1'b0, 1'b1, 1'b0);
    checks++;
    if (q1_o !== 1'b0 || q1_s !== 1'b0 || q2_s !== 1'b1) begin
      errors++;
      $display("FAIL modes_e0 got opp_q1=%b same_q1=%b same_q2=%b exp 0 0 1", q1_o, q1_s, q2_s);
    end
    checks++;
    if (q1_p !== 1'b1 || q2_p !== 1'b0) begin
      errors++;
      $display("FAIL modes_pipe_e0 got %b%b exp 10", q1_p, q2_p);
    end
    send_pair(1'b1, 1'b0, 1'b0);
    checks++;
    if (neg_q2_o !== 1'b1 || neg_q1_o !== 1'b0) begin
      errors++;
      $display("FAIL modes_opp_negedge got q1=%b q2=%b exp q1=0 q2=1", neg_q1_o, neg_q2_o);
    end
    checks++;
    if (q1_o !== 1'b1 || q2_o !== 1'b1) begin
      errors++;
      $display("FAIL modes_opp_e1 got %b%b exp 11", q1_o, q2_o);
    end
    checks++;
    if (q1_s !== 1'b1 || q2_s !== 1'b1) begin
      errors++;
      $display("FAIL modes_same_e1 got %b%b exp 11", q1_s, q2_s);
    end
    checks++;
    if (q1_p !== 1'b0 || q2_p !== 1'b1) begin
      errors++;
      $display("FAIL modes_pipe_e1 got %b%b exp 01", q1_p, q2_p);
    end
    send_pair(1'b1, 1'b0, 1'b0);
    checks++;
    if (neg_q2_o !== 1'b0 || neg_q1_o !== 1'b1) begin
      errors++;
      $display("FAIL modes_opp_negedge2 got q1=%b q2=%b exp q1=1 q2=0", neg_q1_o, neg_q2_o);
    end
    checks++;
    if (q1_p !== 1'b1 || q2_p !== 1'b0 || q1_s !== 1'b1 || q2_s !== 1'b0) begin
      errors++;
      $display("FAIL modes_e2 got pipe=%b%b same=%b%b exp 10 10", q1_p, q2_p, q1_s, q2_s);
    end
    finish_stream("modes");
  endtask

  task automatic test_deserialize();
    do_reset("deser");
    for (int i = 0; i < 14; i++) begin
      send_pair(pat[i % 4][1], pat[i % 4][0], 1'b0);
    end
    do_reset("deser_midword");
    for (int i = 0; i < 4; i++) begin
      send_pair(pat[i][1], pat[i][0], 1'b0);
    end
    finish_stream("deser");
  endtask

  task automatic test_slip();
    do_reset("slip");
    for (int i = 0; i < 14; i++) begin
      send_pair(slip_seq[i][2], slip_seq[i][1], slip_seq[i][0]);
    end
    finish_stream("slip");
  endtask

  task automatic test_ce_set();
    do_reset("ce_set");
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b1, 1'b1, 1'b0);
    stall(3);
    send_pair(1'b0, 1'b0, 1'b0);
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b1, 1'b1, 1'b0);
    @(negedge C);
    #1;
    S = 1'b1;
    CE = 1'b1;
    @(posedge C);
    #1;
    pend = 1'b0;
    m_cnt = 0;
    checks++;
    if (q1_p !== 1'b1 || q2_p !== 1'b1 || word_p !== 8'hB2) begin
      errors++;
      $display("FAIL set got q1=%b q2=%b word=%h exp 1 1 b2", q1_p, q2_p, word_p);
    end
    pend = 1'b1;
    pr = 1'b1;
    pf = 1'b1;
    pa = 1'b0;
    ALIGN = 1'b0;
    send_pair(1'b0, 1'b0, 1'b0);
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b1, 1'b1, 1'b0);
    finish_stream("ce_set");
  endtask

  initial begin
    test_reset();
    test_modes();
    test_deserialize();
    test_slip();
    test_ce_set();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
